// File: rtl/core_mem_arbiter.sv
// Shares one waitrequest/readdatavalid memory bus between the fetch and data ports.
// Data has priority; a streak counter caps consecutive data grants while a fetch waits.
module core_mem_arbiter #(
  parameter int ADDR_W          = 30,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_start,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_start,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_wr,
  input  logic [3:0]        d_be,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_data_rd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_read,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_data_wr,
  output logic [3:0]        bus_be,
  input  logic              bus_waitrequest,
  input  logic [DATA_W-1:0] bus_data_rd,
  input  logic              bus_rd_valid
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CMD    = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                gnt_data_q, gnt_data_d;
  logic                if_pend_q, if_pend_d;
  logic [ADDR_W-1:0]   if_addr_q, if_addr_d;
  logic                d_pend_q, d_pend_d;
  logic                d_write_q, d_write_d;
  logic [ADDR_W-1:0]   d_addr_q, d_addr_d;
  logic [DATA_W-1:0]   d_wdata_q, d_wdata_d;
  logic [3:0]          d_be_q, d_be_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic                bus_read_q, bus_read_d;
  logic                bus_write_q, bus_write_d;
  logic [DATA_W-1:0]   bus_data_wr_q, bus_data_wr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic                if_ready_q, if_ready_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic                d_ready_q, d_ready_d;
  logic [DATA_W-1:0]   d_data_rd_q, d_data_rd_d;

  logic                done, capture;
  logic                if_req, d_req, fetch_wins, if_accept, d_accept;
  logic [ADDR_W-1:0]   if_addr_eff, d_addr_eff;
  logic                d_write_eff;
  logic [DATA_W-1:0]   d_wdata_eff;
  logic [3:0]          d_be_eff;

  // A fresh start is visible to arbitration in the same IDLE cycle; the command itself is registered.
  assign if_req      = if_pend_q | if_start;
  assign d_req       = d_pend_q | d_start;
  assign if_addr_eff = if_pend_q ? if_addr_q : if_addr;
  assign d_addr_eff  = d_pend_q ? d_addr_q : d_addr;
  assign d_write_eff = d_pend_q ? d_write_q : d_write;
  assign d_wdata_eff = d_pend_q ? d_wdata_q : d_data_wr;
  assign d_be_eff    = d_pend_q ? d_be_q : d_be;
  assign fetch_wins  = if_req & (~d_req | (streak_q == STREAK_MAX));

  // A port may re-request in the very cycle its ready pulses.
  assign if_accept = if_start & (~if_pend_q | ((state_q == S_RESP) & ~gnt_data_q));
  assign d_accept  = d_start & (~d_pend_q | ((state_q == S_RESP) & gnt_data_q));

  always_comb begin
    state_d       = state_q;
    gnt_data_d    = gnt_data_q;
    if_pend_d     = if_pend_q;
    if_addr_d     = if_addr_q;
    d_pend_d      = d_pend_q;
    d_write_d     = d_write_q;
    d_addr_d      = d_addr_q;
    d_wdata_d     = d_wdata_q;
    d_be_d        = d_be_q;
    streak_d      = streak_q;
    bus_addr_d    = bus_addr_q;
    bus_read_d    = bus_read_q;
    bus_write_d   = bus_write_q;
    bus_data_wr_d = bus_data_wr_q;
    bus_be_d      = bus_be_q;
    if_ready_d    = 1'b0;
    if_data_d     = if_data_q;
    d_ready_d     = 1'b0;
    d_data_rd_d   = d_data_rd_q;
    done          = 1'b0;
    capture       = 1'b0;

    if (!if_pend_q) streak_d = '0;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d = S_CMD;
          if (fetch_wins) begin
            gnt_data_d    = 1'b0;
            bus_addr_d    = if_addr_eff;
            bus_read_d    = 1'b1;
            bus_write_d   = 1'b0;
            bus_data_wr_d = '0;
            bus_be_d      = 4'hF;
            streak_d      = '0;
          end else begin
            gnt_data_d    = 1'b1;
            bus_addr_d    = d_addr_eff;
            bus_read_d    = ~d_write_eff;
            bus_write_d   = d_write_eff;
            bus_data_wr_d = d_write_eff ? d_wdata_eff : '0;
            bus_be_d      = d_write_eff ? d_be_eff : 4'hF;
            streak_d      = if_req ? streak_q + STREAK_W'(1) : '0;
          end
        end
      end
      S_CMD: begin
        if (!bus_waitrequest) begin
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          if (bus_write_q) begin
            done = 1'b1;
          end else if (bus_rd_valid) begin
            capture = 1'b1;
            done    = 1'b1;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        if (bus_rd_valid) begin
          capture = 1'b1;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      state_d = S_RESP;
      if (gnt_data_q) d_ready_d = 1'b1;
      else            if_ready_d = 1'b1;
    end
    if (capture) begin
      if (gnt_data_q) d_data_rd_d = bus_data_rd;
      else            if_data_d = bus_data_rd;
    end

    if (state_q == S_RESP) begin
      if (gnt_data_q) d_pend_d = 1'b0;
      else            if_pend_d = 1'b0;
    end
    if (if_accept) begin
      if_pend_d = 1'b1;
      if_addr_d = if_addr;
    end
    if (d_accept) begin
      d_pend_d  = 1'b1;
      d_write_d = d_write;
      d_addr_d  = d_addr;
      d_wdata_d = d_data_wr;
      d_be_d    = d_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gnt_data_q    <= 1'b0;
      if_pend_q     <= 1'b0;
      if_addr_q     <= '0;
      d_pend_q      <= 1'b0;
      d_write_q     <= 1'b0;
      d_addr_q      <= '0;
      d_wdata_q     <= '0;
      d_be_q        <= '0;
      streak_q      <= '0;
      bus_addr_q    <= '0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_data_wr_q <= '0;
      bus_be_q      <= '0;
      if_ready_q    <= 1'b0;
      if_data_q     <= '0;
      d_ready_q     <= 1'b0;
      d_data_rd_q   <= '0;
    end else begin
      state_q       <= state_d;
      gnt_data_q    <= gnt_data_d;
      if_pend_q     <= if_pend_d;
      if_addr_q     <= if_addr_d;
      d_pend_q      <= d_pend_d;
      d_write_q     <= d_write_d;
      d_addr_q      <= d_addr_d;
      d_wdata_q     <= d_wdata_d;
      d_be_q        <= d_be_d;
      streak_q      <= streak_d;
      bus_addr_q    <= bus_addr_d;
      bus_read_q    <= bus_read_d;
      bus_write_q   <= bus_write_d;
      bus_data_wr_q <= bus_data_wr_d;
      bus_be_q      <= bus_be_d;
      if_ready_q    <= if_ready_d;
      if_data_q     <= if_data_d;
      d_ready_q     <= d_ready_d;
      d_data_rd_q   <= d_data_rd_d;
    end
  end

  assign if_ready    = if_ready_q;
  assign if_data     = if_data_q;
  assign d_ready     = d_ready_q;
  assign d_data_rd   = d_data_rd_q;
  assign bus_addr    = bus_addr_q;
  assign bus_read    = bus_read_q;
  assign bus_write   = bus_write_q;
  assign bus_data_wr = bus_data_wr_q;
  assign bus_be      = bus_be_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a small bus slave model plus a linear
// sequence of steps with hand-computed expectations checked by immediate assertions.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_start = 1'b0;
  logic [29:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_data;
  logic        d_start = 1'b0;
  logic        d_write = 1'b0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_data_wr = '0;
  logic [3:0]  d_be = '0;
  logic        d_ready;
  logic [31:0] d_data_rd;
  logic [29:0] bus_addr;
  logic        bus_read, bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_be;
  logic        bus_waitrequest = 1'b0;
  logic [31:0] bus_data_rd = '0;
  logic        bus_rd_valid = 1'b0;

  core_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_start(if_start), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .d_start(d_start), .d_write(d_write), .d_addr(d_addr), .d_data_wr(d_data_wr),
    .d_be(d_be), .d_ready(d_ready), .d_data_rd(d_data_rd),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_be(bus_be), .bus_waitrequest(bus_waitrequest),
    .bus_data_rd(bus_data_rd), .bus_rd_valid(bus_rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int if_cnt = 0;
  int d_cnt  = 0;
  logic [29:0] grant_log[$];

  // slave model controls
  int          stall_cfg = 0;
  bit          slave_mute = 1'b0;
  bit          stray_rdv = 1'b0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;

  function automatic logic [31:0] exp_rd(input logic [29:0] a);
    return 32'h5A000000 ^ {2'b00, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit is_d, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (((is_d ? d_ready : if_ready) !== 1'b1) && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, {63'd0, (is_d ? d_ready : if_ready)}, 64'd1);
  endtask

  // Bus slave: zero-wait unless stall_cfg, read data one cycle after acceptance.
  bit          acc_rd, in_cmd, cmd_now;
  logic [29:0] acc_addr;
  int          wait_left = 0;
  always begin
    @(posedge clk);
    acc_rd   = bus_read & ~bus_waitrequest & ~rst;
    acc_addr = bus_addr;
    #2;
    if (rst) begin
      in_cmd    = 1'b0;
      wait_left = 0;
    end
    bus_rd_valid = (acc_rd & ~slave_mute) | stray_rdv;
    if (stray_rdv)   bus_data_rd = 32'hBAD0BAD0;
    else if (acc_rd) bus_data_rd = fixed_en ? fixed_data : exp_rd(acc_addr);
    cmd_now = bus_read | bus_write;
    if (cmd_now && !in_cmd) begin
      in_cmd    = 1'b1;
      wait_left = stall_cfg;
    end else if (cmd_now && wait_left > 0) begin
      wait_left--;
    end
    if (!cmd_now) in_cmd = 1'b0;
    bus_waitrequest = cmd_now && (wait_left > 0);
  end

  // Transaction monitor: grant log, ready counts, read/write exclusivity.
  bit cmd_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cmd_prev = 1'b0;
    end else begin
      if ((bus_read | bus_write) && !cmd_prev) grant_log.push_back(bus_addr);
      cmd_prev = bus_read | bus_write;
      chk("rw_exclusive", {63'd0, bus_read & bus_write}, 64'd0);
      if (if_ready) begin
        if_cnt++;
        $display("txn %0t: fetch ready data=%h", $time, if_data);
      end
      if (d_ready) begin
        d_cnt++;
        $display("txn %0t: data ready rdata=%h", $time, d_data_rd);
      end
    end
  end

  logic [29:0] starv_exp [7] = '{30'h40, 30'h41, 30'h42, 30'h43, 30'h101, 30'h44, 30'h45};
  int base_if, base_d, issued;

  initial begin
    // Reset state
    step(); step(); step();
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_bus_read", bus_read, 0);
    chk("rst_bus_write", bus_write, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_d_data_rd", d_data_rd, 0);
    rst = 1'b0;
    step();

    // Fetch only: start cycle 1, command cycle 2, ready cycle 4
    fixed_en = 1'b1; fixed_data = 32'hDEADBEEF;
    if_start = 1'b1; if_addr = 30'h10;
    step(); if_start = 1'b0; if_addr = 30'h3FF;
    chk("f_cmd_read", bus_read, 1);
    chk("f_cmd_addr", bus_addr, 30'h10);
    chk("f_cmd_be", bus_be, 4'hF);
    chk("f_cmd_write", bus_write, 0);
    step();
    chk("f_cmd_dropped", bus_read, 0);
    chk("f_no_early_ready", if_ready, 0);
    step();
    chk("f_ready", if_ready, 1);
    chk("f_data", if_data, 32'hDEADBEEF);
    chk("f_no_d_ready", d_ready, 0);
    step();
    chk("f_ready_one_cycle", if_ready, 0);
    step(); step();
    chk("f_data_held", if_data, 32'hDEADBEEF);
    fixed_en = 1'b0;

    // Write with three stall cycles
    stall_cfg = 3;
    d_start = 1'b1; d_write = 1'b1; d_addr = 30'h3; d_data_wr = 32'h12345678; d_be = 4'b0011;
    step();
    d_start = 1'b0; d_addr = 30'h7777; d_data_wr = 32'hFFFFFFFF; d_be = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w_write_c%0d", i), bus_write, 1);
      chk($sformatf("w_read_c%0d", i), bus_read, 0);
      chk($sformatf("w_addr_c%0d", i), bus_addr, 30'h3);
      chk($sformatf("w_wdata_c%0d", i), bus_data_wr, 32'h12345678);
      chk($sformatf("w_be_c%0d", i), bus_be, 4'b0011);
      chk($sformatf("w_no_ready_c%0d", i), d_ready, 0);
      step();
    end
    chk("w_d_ready", d_ready, 1);
    chk("w_cmd_dropped", bus_write, 0);
    chk("w_d_data_rd_unchanged", d_data_rd, 0);
    step();
    chk("w_d_ready_one_cycle", d_ready, 0);
    stall_cfg = 0; d_write = 1'b0;
    step();

    // Collision: data first, then fetch, one ready each
    grant_log.delete(); base_if = if_cnt; base_d = d_cnt;
    if_start = 1'b1; if_addr = 30'h100;
    d_start = 1'b1; d_write = 1'b0; d_addr = 30'h20;
    step(); if_start = 1'b0; d_start = 1'b0;
    for (int n = 0; n < 40 && (if_cnt - base_if) < 1; n++) step();
    step(); step(); step(); step();
    chk("col_if_ready_count", if_cnt - base_if, 1);
    chk("col_d_ready_count", d_cnt - base_d, 1);
    chk("col_grant_count", grant_log.size(), 2);
    chk("col_first_grant", grant_log[0], 30'h20);
    chk("col_second_grant", grant_log[1], 30'h100);
    chk("col_d_data", d_data_rd, exp_rd(30'h20));
    chk("col_if_data", if_data, exp_rd(30'h100));

    // Starvation bound: four data grants, then fetch, then data resumes
    grant_log.delete(); base_if = if_cnt; base_d = d_cnt;
    if_start = 1'b1; if_addr = 30'h101;
    d_start = 1'b1; d_addr = 30'h40; issued = 1;
    step(); if_start = 1'b0; d_start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (d_ready === 1'b1 && issued < 6) begin
        d_start = 1'b1;
        d_addr  = 30'h40 + 30'(issued);
        issued++;
      end
      step();
      d_start = 1'b0;
      if ((d_cnt - base_d) == 6 && (if_cnt - base_if) == 1) break;
    end
    chk("starv_d_count", d_cnt - base_d, 6);
    chk("starv_if_count", if_cnt - base_if, 1);
    chk("starv_grant_count", grant_log.size(), 7);
    for (int i = 0; i < 7 && i < grant_log.size(); i++)
      chk($sformatf("starv_grant%0d", i), grant_log[i], starv_exp[i]);
    chk("starv_if_data", if_data, exp_rd(30'h101));
    chk("starv_d_data", d_data_rd, exp_rd(30'h45));
    step(); step();

    // Reset during RDWAIT, then a stray rd_valid
    base_if = if_cnt;
    slave_mute = 1'b1;
    if_start = 1'b1; if_addr = 30'h55;
    step(); if_start = 1'b0;
    chk("rr_cmd", bus_read, 1);
    step();
    chk("rr_accepted", bus_read, 0);
    step();
    rst = 1'b1;
    step();
    chk("rr_bus_read", bus_read, 0);
    chk("rr_bus_addr", bus_addr, 0);
    chk("rr_bus_be", bus_be, 0);
    chk("rr_if_ready", if_ready, 0);
    chk("rr_if_data", if_data, 0);
    chk("rr_d_data_rd", d_data_rd, 0);
    rst = 1'b0; slave_mute = 1'b0; stray_rdv = 1'b1;
    step(); stray_rdv = 1'b0;
    chk("rr_stray_if_ready", if_ready, 0);
    step();
    chk("rr_stray_if_ready2", if_ready, 0);
    chk("rr_stray_if_data", if_data, 0);
    chk("rr_idle_no_cmd", bus_read, 0);
    if_start = 1'b1; if_addr = 30'h66;
    step(); if_start = 1'b0;
    chk("rr_fresh_cmd", bus_read, 1);
    chk("rr_fresh_addr", bus_addr, 30'h66);
    step(); step();
    chk("rr_fresh_ready", if_ready, 1);
    chk("rr_fresh_data", if_data, exp_rd(30'h66));
    step();
    chk("rr_ready_count", if_cnt - base_if, 1);

    // Protocol edges: ignored second d_start; if_start latched with if_ready
    grant_log.delete(); base_if = if_cnt; base_d = d_cnt;
    d_start = 1'b1; d_write = 1'b0; d_addr = 30'h70;
    step();
    d_addr = 30'h71;
    step(); d_start = 1'b0;
    wait_ready(1'b1, 20, "pe_d_ready");
    for (int i = 0; i < 10; i++) step();
    chk("pe_d_count", d_cnt - base_d, 1);
    chk("pe_d_grants", grant_log.size(), 1);
    chk("pe_d_addr", grant_log[0], 30'h70);
    chk("pe_d_data", d_data_rd, exp_rd(30'h70));
    if_start = 1'b1; if_addr = 30'h80;
    step(); if_start = 1'b0;
    wait_ready(1'b0, 20, "pe_if_ready1");
    if_start = 1'b1; if_addr = 30'h81;
    step(); if_start = 1'b0;
    chk("pe_if_data1", if_data, exp_rd(30'h80));
    wait_ready(1'b0, 20, "pe_if_ready2");
    chk("pe_if_data2", if_data, exp_rd(30'h81));
    step(); step();
    chk("pe_if_count", if_cnt - base_if, 2);
    chk("pe_total_grants", grant_log.size(), 3);
    chk("pe_second_fetch_addr", grant_log[2], 30'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one external memory bus between the instruction-fetch port and the data port of core control.
- Each requester uses the core start/ready pulse handshake.
- The bus side is a waitrequest/readdatavalid master with at most one transaction outstanding.
- Data accesses have priority. A streak limit guarantees fetch progress.

Parameters:
ADDR_W, 30, word-address width (ptr)
DATA_W, 32, data width (word)
MAX_DATA_STREAK, 4, max consecutive data grants while a fetch is pending (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_start  in  1  fetch request pulse (read only)
if_addr  in  ADDR_W  fetch word address, sampled with if_start
if_ready  out  1  one-cycle pulse: fetch complete
if_data  out  DATA_W  fetch read data, valid with if_ready, held until next if_ready
d_start  in  1  data request pulse
d_write  in  1  1=write, 0=read, sampled with d_start
d_addr  in  ADDR_W  data word address
d_data_wr  in  DATA_W  write data
d_be  in  4  byte enables (write only)
d_ready  out  1  one-cycle pulse: data access complete
d_data_rd  out  DATA_W  read data, valid with d_ready, held until next d_ready
bus_addr  out  ADDR_W  bus address
bus_read  out  1  read command
bus_write  out  1  write command
bus_data_wr  out  DATA_W  bus write data
bus_be  out  4  bus byte enables (4'b1111 on reads)
bus_waitrequest  in  1  slave stall; command is accepted on a cycle with command high and waitrequest low
bus_data_rd  in  DATA_W  read return data
bus_rd_valid  in  1  read data valid

Behaviour:
- Request latching:
  - Each port has a pending register, set on its start pulse; it captures addr/write/data/be.
  - A start on a port that already has a pending or in-flight request is ignored; the bench asserts on it.
  - A start in the same cycle as that port's ready is legal and is latched.
- FSM states: IDLE, CMD, RDWAIT, RESP.
- IDLE:
  - If any request is pending, grant one.
  - Drive bus_* from registers in the next cycle and go to CMD.
  - The command is never driven combinationally from start; minimum start-to-command latency is 1 cycle.
- CMD:
  - Hold bus_addr/data/be/read/write stable while bus_waitrequest=1.
  - On acceptance, drop the command the next cycle.
  - Write: go to RESP.
  - Read: go to RDWAIT. If bus_rd_valid is high in the acceptance cycle, capture the data and go to RESP.
- RDWAIT: on bus_rd_valid, capture bus_data_rd into the granted port's data register and go to RESP.
- RESP:
  - Pulse the granted port's ready for exactly 1 cycle and clear its pending flag.
  - Go to IDLE. Back-to-back grant: next command in the following cycle.
- Arbitration (evaluated only in IDLE):
  - Data wins over fetch.
  - streak counter: increments on each data grant while if pending; cleared on a fetch grant or when no fetch is pending.
  - When streak == MAX_DATA_STREAK and fetch is pending, fetch wins.
- bus_read and bus_write are never high together. No command is issued outside CMD.
- bus_rd_valid outside CMD/RDWAIT is ignored.
- Reset values:
  - All outputs 0, state IDLE.
  - Pending flags, streak and data registers cleared.
- Reset mid-transaction: abandon it. Command is low the cycle after rst; no ready pulse is issued for the abandoned request; a late bus_rd_valid is ignored.
- Latency with zero-wait slave and 1-cycle read return: start t, command t+1, rd_valid t+2, ready t+3. Write: ready t+2.

Test Plan:
- Fetch only:
  - Stimulus: if_start at cycle 1, if_addr=0x10; slave waitrequest=0, returns 0xDEADBEEF one cycle after acceptance.
  - Response: bus_read at 2 with addr 0x10; if_ready at 4 with if_data=0xDEADBEEF; if_data held afterwards.
- Write with stalls:
  - Stimulus: d_start, d_write=1, addr 0x3, data 0x12345678, be 4'b0011; waitrequest high 3 cycles.
  - Response: command and all bus fields stable 4 cycles, bus_be=4'b0011; d_ready one cycle after acceptance; d_data_rd unchanged.
- Collision:
  - Stimulus: if_start and d_start in the same cycle.
  - Response: data command issued first; fetch command follows RESP back-to-back; each port gets exactly one ready.
- Starvation bound:
  - Stimulus: fetch pending; data requests re-issued on every d_ready; MAX_DATA_STREAK=4.
  - Response: exactly 4 data grants, then the fetch is granted, then data resumes.
- Reset mid-read:
  - Stimulus: rst during RDWAIT, then a stray bus_rd_valid.
  - Response: no ready pulse; outputs 0; state IDLE; a fresh fetch after reset completes normally.
- Protocol edges:
  - Stimulus: second d_start while a data request is in flight; new if_start in the same cycle as if_ready.
  - Response: the first is ignored (one d_ready only); the second is latched and served.
